// File: rtl/display_scan_controller_if.sv
// -----------------------------------------------------------------------------
// display_scan_controller_if
//   Groups the update handshake and the display drive outputs of the scan
//   controller.
//
//   load       : update request, master -> slave
//   digits_in  : BCD digits, digit 0 in [3:0], master -> slave
//   ready      : no pending update, slave -> master
//   valor      : code for the shared 7-segment decoder (4'hF = blank)
//   digit_en   : active-low one-hot digit enable
//   frame_tick : one-cycle pulse on the last cycle of each frame
//
//   master : the update source / observer (drives load and digits_in)
//   slave  : the scan controller
// -----------------------------------------------------------------------------
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic                      ready;
    logic [3:0]                valor;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      frame_tick;

    modport master (
        output load,
        output digits_in,
        input  ready,
        input  valor,
        input  digit_en,
        input  frame_tick
    );

    modport slave (
        input  load,
        input  digits_in,
        output ready,
        output valor,
        output digit_en,
        output frame_tick
    );
endinterface

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//   Time-multiplexed scan of NUM_DIGITS common-anode digits through one
//   shared 7-segment decoder. Each digit slot lasts REFRESH_DIV cycles and
//   begins with BLANK_CYCLES guard cycles (all digits off, valor = 4'hF) to
//   avoid ghosting. New digits arrive through a load/ready handshake into a
//   pending buffer and are copied to the displayed buffer only at frame end,
//   so a frame never shows a mix of old and new digits.
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : display_scan_controller_if.slave
//            (load, digits_in, ready, valor, digit_en, frame_tick)
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     When defined, digit i (i >= 1) is blanked during its SHOW phase if it
//     and all higher digits are zero. Digit 0 is always shown.
//
//   All outputs are registered: the next-state values are decoded and the
//   output flops load them together with the state flops.
// -----------------------------------------------------------------------------
module display_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    display_scan_controller_if.slave  bus
);
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t                      state_q, state_d;
    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]  pend_q, pend_d;
    logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_d;
    logic                        pend_valid_q, pend_valid_d;
    logic                        ready_q, ready_d;
    logic [3:0]                  valor_q, valor_d;
    logic [NUM_DIGITS-1:0]       en_q, en_d;
    logic                        tick_q, tick_d;

    logic                        slot_end;
    logic                        frame_end;
    logic                        blank_lz;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]       lz;
    logic                        zero_run;
`endif

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        disp_d       = disp_q;
        pend_valid_d = pend_valid_q;
        blank_lz     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz           = '0;
        zero_run     = 1'b1;
`endif

        slot_end  = (slot_q == SLOT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        // Slot and digit counters
        if (slot_end) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end

        case (state_q)
            BLANK:   if (slot_q == BLANK_LAST) state_d = SHOW;
            SHOW:    if (slot_end)             state_d = BLANK;
            default:                           state_d = BLANK;
        endcase

        // Commit uses the flag as it stood before this cycle, so a load taken
        // on the frame-end cycle waits for the following frame end. Capture
        // and commit are exclusive because capture needs the flag clear.
        if (frame_end && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end else if (bus.load && !pend_valid_q) begin
            pend_d       = bus.digits_in;
            pend_valid_d = 1'b1;
        end

`ifdef LEADING_ZERO_BLANK_EN
        // lz[i] = digit i and every higher digit are zero
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_d[i] == 4'd0);
            lz[i]    = zero_run;
        end
        blank_lz = (idx_d != '0) && lz[idx_d];
`endif

        // Output decode from next state so the flops present current state
        if ((state_d == SHOW) && !blank_lz) begin
            valor_d = disp_d[idx_d];
            en_d    = ~(NUM_DIGITS'(1) << idx_d);
        end else begin
            valor_d = 4'hF;
            en_d    = '1;
        end
        tick_d  = (slot_d == SLOT_LAST) && (idx_d == IDX_LAST);
        ready_d = ~pend_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BLANK;
            slot_q       <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            disp_q       <= '0;
            pend_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            valor_q      <= 4'hF;
            en_q         <= '1;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            pend_valid_q <= pend_valid_d;
            ready_q      <= ready_d;
            valor_q      <= valor_d;
            en_q         <= en_d;
            tick_q       <= tick_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.valor      = valor_q;
    assign bus.digit_en   = en_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
//   Directed bench for display_scan_controller with NUM_DIGITS=4,
//   REFRESH_DIV=8, BLANK_CYCLES=2. Cycle 0 is the first cycle with rst=0;
//   inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;
    localparam int ND = 4;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    display_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_controller #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    task automatic to_cycle(input int c);
        if (c > cyc) step(c - cyc);
    endtask

    // Leaves the bench in cycle 0 (reset state visible, rst low)
    task automatic do_reset();
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic load_now(input logic [15:0] d);
        bus.load      = 1'b1;
        bus.digits_in = d;
        step(1);
        bus.load      = 1'b0;
        bus.digits_in = '0;
    endtask

    task automatic chk_show(input string tag, input int c, input logic [3:0] v, input logic [3:0] en);
        to_cycle(c);
        chk({tag, ".valor"}, {12'd0, bus.valor}, {12'd0, v});
        chk({tag, ".en"}, {12'd0, bus.digit_en}, {12'd0, en});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;

        // Reset values and first SHOW cycle
        do_reset();
        chk("rst.ready", {15'd0, bus.ready}, 16'd1);
        chk("rst.valor", {12'd0, bus.valor}, 16'hF);
        chk("rst.en", {12'd0, bus.digit_en}, 16'hF);
        chk("rst.tick", {15'd0, bus.frame_tick}, 16'd0);
        chk_show("c1", 1, 4'hF, 4'b1111);
        chk_show("c2", 2, 4'h0, 4'b1110);

        // Commit at frame end, plus a load while busy that must be ignored
        do_reset();
        load_now(16'h1234);
        chk("busy.ready1", {15'd0, bus.ready}, 16'd0);
        to_cycle(5);
        load_now(16'h9999);
        chk("busy.ready6", {15'd0, bus.ready}, 16'd0);
        to_cycle(30);
        chk("tick30", {15'd0, bus.frame_tick}, 16'd0);
        chk_show("old.d3", 30, 4'h0, 4'b0111);
        to_cycle(31);
        chk("tick31", {15'd0, bus.frame_tick}, 16'd1);
        chk("ready31", {15'd0, bus.ready}, 16'd0);
        to_cycle(32);
        chk("ready32", {15'd0, bus.ready}, 16'd1);
        chk("tick32", {15'd0, bus.frame_tick}, 16'd0);
        chk_show("blank32", 32, 4'hF, 4'b1111);
        chk_show("d0.34", 34, 4'h4, 4'b1110);
        chk_show("d0.39", 39, 4'h4, 4'b1110);
        chk_show("guard40", 40, 4'hF, 4'b1111);
        chk_show("d1.42", 42, 4'h3, 4'b1101);
        chk_show("d2.50", 50, 4'h2, 4'b1011);
        chk_show("d3.58", 58, 4'h1, 4'b0111);
        chk_show("d3.63", 63, 4'h1, 4'b0111);
        chk("ready63", {15'd0, bus.ready}, 16'd1);

        // Load on the frame-end cycle commits one frame later
        do_reset();
        to_cycle(31);
        chk("fe.tick31", {15'd0, bus.frame_tick}, 16'd1);
        load_now(16'h5678);
        chk("fe.ready32", {15'd0, bus.ready}, 16'd0);
        chk_show("fe.d0.34", 34, 4'h0, 4'b1110);
        to_cycle(63);
        chk("fe.tick63", {15'd0, bus.frame_tick}, 16'd1);
        chk("fe.ready63", {15'd0, bus.ready}, 16'd0);
        to_cycle(64);
        chk("fe.ready64", {15'd0, bus.ready}, 16'd1);
        chk_show("fe.d0.66", 66, 4'h8, 4'b1110);
        chk_show("fe.d0.71", 71, 4'h8, 4'b1110);

        // Mid-frame reset discards the pending update
        do_reset();
        load_now(16'h1234);
        chk_show("mr.c20", 20, 4'h0, 4'b1011);
        rst = 1'b1;
        step(1);
        chk("mr.ready", {15'd0, bus.ready}, 16'd1);
        chk("mr.valor", {12'd0, bus.valor}, 16'hF);
        chk("mr.en", {12'd0, bus.digit_en}, 16'hF);
        chk("mr.tick", {15'd0, bus.frame_tick}, 16'd0);
        rst = 1'b0;
        cyc = 0;
        to_cycle(31);
        chk("mr.tick31", {15'd0, bus.frame_tick}, 16'd1);
        chk_show("mr.d0.34", 34, 4'h0, 4'b1110);
        chk_show("mr.d3.58", 58, 4'h0, 4'b0111);
        chk("mr.ready58", {15'd0, bus.ready}, 16'd1);

`ifdef LEADING_ZERO_BLANK_EN
        // Leading zeros above the 5 are blanked; digit 0 still shows 0
        do_reset();
        load_now(16'h0050);
        chk_show("lz.d0", 34, 4'h0, 4'b1110);
        chk_show("lz.d1", 42, 4'h5, 4'b1101);
        chk_show("lz.d2", 50, 4'hF, 4'b1111);
        chk_show("lz.d3", 58, 4'hF, 4'b1111);
`else
        // Non-BCD code passes through with its enable driven; zeros shown
        do_reset();
        load_now(16'h00A0);
        chk_show("pt.d0", 34, 4'h0, 4'b1110);
        chk_show("pt.d1", 42, 4'hA, 4'b1101);
        chk_show("pt.d2", 50, 4'h0, 4'b1011);
        chk_show("pt.d3", 58, 4'h0, 4'b0111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
